// File: rtl/muldiv_unit.sv
// Iterative RISC-V M-extension multiply/divide unit with valid/ready handshakes and flush.
// Define MULDIV_FAST_MUL_EN for a single-cycle combinational multiplier; divides stay iterative.
module muldiv_unit #(
  parameter int LEN      = 64,
  parameter int WORD_OPS = 1,
  parameter int TAG_W    = 5
) (
  input  logic             clk,
  input  logic             nrst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [2:0]       in_funct3,
  input  logic             in_word,
  input  logic [LEN-1:0]   in_src1,
  input  logic [LEN-1:0]   in_src2,
  input  logic [TAG_W-1:0] in_tag,
  input  logic             flush,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [LEN-1:0]   out_res,
  output logic [TAG_W-1:0] out_tag
);
  localparam int CW = $clog2(LEN + 1);

  typedef enum logic [1:0] {IDLE = 2'd0, BUSY = 2'd1, DONE = 2'd2} state_t;

  state_t           state_q, state_d;
  logic [LEN:0]     a_q, a_d;
  logic [LEN-1:0]   q_q, q_d, m_q, m_d, res_q, res_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic [2:0]       op_q, op_d;
  logic             word_q, word_d, neg_q, neg_d;
  logic [TAG_W-1:0] tag_q, tag_d;

  logic             word_s, s1sg_s, s2sg_s, sg1_s, sg2_s, neg_s, div0_s, ovf_s;
  logic [LEN-1:0]   x1_s, x2_s, mag1_s, mag2_s, dvd_s, min_s, spec_s;
  logic [CW-1:0]    cnt_init_s;
  logic [LEN:0]     mul_sum_s, mul_a_s, div_sh_s, div_a_s;
  logic [LEN-1:0]   mul_q_s, div_q_s, quo_n_s, rem_n_s, fin_s;
  logic             div_ge_s;
  logic [2*LEN-1:0] prod_s, prod_n_s;

  // Sign-extend a word-mode value from bit 31 to the full width
  function automatic logic [LEN-1:0] wfix(input logic [LEN-1:0] v, input logic w);
    logic signed [31:0] lo;
    lo = v[31:0];
    if (w) wfix = LEN'(lo);
    else   wfix = v;
  endfunction

  function automatic logic [LEN-1:0] ext(input logic [LEN-1:0] v, input logic w, input logic sgn);
    if (!w)       ext = v;
    else if (sgn) ext = wfix(v, 1'b1);
    else          ext = LEN'(v[31:0]);
  endfunction

  // Decode signedness, normalise operands to magnitudes and detect divide special cases
  always_comb begin
    word_s = (WORD_OPS != 0) && in_word;
    case (in_funct3)
      3'b000, 3'b001, 3'b100, 3'b110: begin s1sg_s = 1'b1; s2sg_s = 1'b1; end
      3'b010:                         begin s1sg_s = 1'b1; s2sg_s = 1'b0; end
      default:                        begin s1sg_s = 1'b0; s2sg_s = 1'b0; end
    endcase
    x1_s  = ext(in_src1, word_s, s1sg_s);
    x2_s  = ext(in_src2, word_s, s2sg_s);
    sg1_s = s1sg_s & x1_s[LEN-1];
    sg2_s = s2sg_s & x2_s[LEN-1];
    if (sg1_s) mag1_s = -x1_s; else mag1_s = x1_s;
    if (sg2_s) mag2_s = -x2_s; else mag2_s = x2_s;
    // Word divides start with the dividend parked at the top so 32 shifts consume it
    if (word_s) begin
      dvd_s      = mag1_s << (LEN - 32);
      min_s      = wfix(LEN'(32'h8000_0000), 1'b1);
      cnt_init_s = CW'(32);
    end else begin
      dvd_s      = mag1_s;
      min_s      = {1'b1, {(LEN-1){1'b0}}};
      cnt_init_s = CW'(LEN);
    end
    div0_s = in_funct3[2] && (x2_s == '0);
    ovf_s  = in_funct3[2] && !in_funct3[0] && (x1_s == min_s) && (x2_s == '1);
    if (in_funct3[2] && in_funct3[1]) neg_s = sg1_s;
    else                              neg_s = sg1_s ^ sg2_s;
    if (in_funct3[1]) begin
      if (div0_s) spec_s = wfix(x1_s, word_s); else spec_s = '0;
    end else begin
      if (div0_s) spec_s = '1; else spec_s = wfix(x1_s, word_s);
    end
  end

`ifdef MULDIV_FAST_MUL_EN
  logic signed [LEN:0]     fa_s, fb_s;
  logic signed [2*LEN+1:0] fp_s;
  logic [LEN-1:0]          fres_s;

  // Single-cycle signed/unsigned multiply of the extended operands
  always_comb begin
    fa_s = {sg1_s, x1_s};
    fb_s = {sg2_s, x2_s};
    fp_s = fa_s * fb_s;
    if (word_s) begin
      if (in_funct3[1:0] == 2'b00) fres_s = wfix(fp_s[LEN-1:0], 1'b1);
      else                         fres_s = '0;
    end else if (in_funct3[1:0] == 2'b00) begin
      fres_s = fp_s[LEN-1:0];
    end else begin
      fres_s = fp_s[2*LEN-1:LEN];
    end
  end
`endif

  // One shift-add / restoring-divide step, plus the sign-corrected final result
  always_comb begin
    if (q_q[0]) mul_sum_s = a_q + {1'b0, m_q};
    else        mul_sum_s = a_q;
    mul_a_s  = {1'b0, mul_sum_s[LEN:1]};
    mul_q_s  = {mul_sum_s[0], q_q[LEN-1:1]};
    div_sh_s = {a_q[LEN-1:0], q_q[LEN-1]};
    div_ge_s = div_sh_s >= {1'b0, m_q};
    if (div_ge_s) div_a_s = div_sh_s - {1'b0, m_q};
    else          div_a_s = div_sh_s;
    div_q_s  = {q_q[LEN-2:0], div_ge_s};
    // A word multiply leaves the product shifted up by LEN-32 after its 32 steps
    prod_s   = {mul_a_s[LEN-1:0], mul_q_s};
    if (neg_q) begin
      prod_n_s = -prod_s;
      quo_n_s  = -div_q_s;
      rem_n_s  = -div_a_s[LEN-1:0];
    end else begin
      prod_n_s = prod_s;
      quo_n_s  = div_q_s;
      rem_n_s  = div_a_s[LEN-1:0];
    end
    if (op_q[2]) begin
      if (op_q[1]) fin_s = wfix(rem_n_s, word_q);
      else         fin_s = wfix(quo_n_s, word_q);
    end else if (word_q) begin
      if (op_q[1:0] == 2'b00) fin_s = wfix(LEN'(prod_n_s[LEN-1 -: 32]), 1'b1);
      else                    fin_s = '0;
    end else if (op_q[1:0] == 2'b00) begin
      fin_s = prod_n_s[LEN-1:0];
    end else begin
      fin_s = prod_n_s[2*LEN-1:LEN];
    end
  end

  // Next-state: launch from IDLE, one iteration per BUSY cycle, hold the result in DONE
  always_comb begin
    state_d = state_q; a_d = a_q; q_d = q_q; m_d = m_q; cnt_d = cnt_q;
    op_d = op_q; word_d = word_q; neg_d = neg_q; res_d = res_q; tag_d = tag_q;
    if (flush) begin
      state_d = IDLE;
      cnt_d   = '0;
    end else begin
      case (state_q)
        IDLE: begin
          if (in_valid) begin
            op_d = in_funct3; word_d = word_s; neg_d = neg_s; tag_d = in_tag;
            a_d = '0; cnt_d = cnt_init_s;
            if (div0_s || ovf_s) begin
              res_d = spec_s; cnt_d = '0; state_d = DONE;
            end else if (in_funct3[2]) begin
              q_d = dvd_s; m_d = mag2_s; state_d = BUSY;
            end else begin
`ifdef MULDIV_FAST_MUL_EN
              res_d = fres_s; cnt_d = '0; state_d = DONE;
`else
              q_d = mag2_s; m_d = mag1_s; state_d = BUSY;
`endif
            end
          end else begin
            state_d = IDLE;
          end
        end
        BUSY: begin
          cnt_d = cnt_q - CW'(1);
          if (op_q[2]) begin a_d = div_a_s; q_d = div_q_s; end
          else         begin a_d = mul_a_s; q_d = mul_q_s; end
          if (cnt_q == CW'(1)) begin res_d = fin_s; state_d = DONE; end
          else                 state_d = BUSY;
        end
        DONE: begin
          if (out_ready) state_d = IDLE;
          else           state_d = DONE;
        end
        default: state_d = IDLE;
      endcase
    end
  end

  // State and datapath registers with synchronous active-low reset
  always_ff @(posedge clk) begin
    if (!nrst) begin
      state_q <= IDLE; a_q <= '0; q_q <= '0; m_q <= '0; cnt_q <= '0;
      op_q <= '0; word_q <= 1'b0; neg_q <= 1'b0; res_q <= '0; tag_q <= '0;
    end else begin
      state_q <= state_d; a_q <= a_d; q_q <= q_d; m_q <= m_d; cnt_q <= cnt_d;
      op_q <= op_d; word_q <= word_d; neg_q <= neg_d; res_q <= res_d; tag_q <= tag_d;
    end
  end

  assign in_ready  = (state_q == IDLE) && nrst;
  assign out_valid = (state_q == DONE);
  assign out_res   = res_q;
  assign out_tag   = tag_q;
endmodule

// File: tb/tb_muldiv_unit.sv
// Self-checking bench for muldiv_unit: directed corner cases, handshake/abort, random vs arithmetic model.
module tb_muldiv_unit;
`ifdef MULDIV_FAST_MUL_EN
  localparam bit FAST = 1'b1;
`else
  localparam bit FAST = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        nrst = 1'b0;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic [2:0]  in_funct3 = 3'd0;
  logic        in_word = 1'b0;
  logic [63:0] in_src1 = 64'd0;
  logic [63:0] in_src2 = 64'd0;
  logic [4:0]  in_tag = 5'd0;
  logic        flush = 1'b0;
  logic        out_valid;
  logic        out_ready = 1'b0;
  logic [63:0] out_res;
  logic [4:0]  out_tag;

  int total = 0;
  int bad = 0;

  muldiv_unit #(.LEN(64), .WORD_OPS(1), .TAG_W(5)) dut (
    .clk(clk), .nrst(nrst), .in_valid(in_valid), .in_ready(in_ready),
    .in_funct3(in_funct3), .in_word(in_word), .in_src1(in_src1), .in_src2(in_src2),
    .in_tag(in_tag), .flush(flush), .out_valid(out_valid), .out_ready(out_ready),
    .out_res(out_res), .out_tag(out_tag)
  );

  always #5 clk = ~clk;

  initial begin
    #5000000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog expired");
  end

  task automatic chk(input string nm, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", nm, obs, exp);
    end
  endtask

  // RISC-V M-extension semantics computed with plain wide arithmetic
  function automatic logic [63:0] model(input logic [2:0] f, input logic w,
                                        input logic [63:0] a, input logic [63:0] b);
    logic signed [129:0] x, y, p;
    longint sa, sb;
    int wa, wb;
    logic [31:0] ua, ub, r32;
    logic [63:0] r;
    r = 64'd0;
    if (!w) begin
      x = (f == 3'b011) ? {66'd0, a} : {{66{a[63]}}, a};
      y = (f[1] && !f[2]) ? {66'd0, b} : {{66{b[63]}}, b};
      p = x * y;
      sa = a; sb = b;
      case (f)
        3'b000: r = p[63:0];
        3'b001, 3'b010, 3'b011: r = p[127:64];
        3'b100: r = (b == 64'd0) ? '1 : ((a == 64'h8000_0000_0000_0000 && b == '1) ? a : 64'(sa / sb));
        3'b101: r = (b == 64'd0) ? '1 : a / b;
        3'b110: r = (b == 64'd0) ? a : ((a == 64'h8000_0000_0000_0000 && b == '1) ? 64'd0 : 64'(sa % sb));
        default: r = (b == 64'd0) ? a : a % b;
      endcase
    end else begin
      ua = a[31:0]; ub = b[31:0]; wa = ua; wb = ub;
      case (f)
        3'b000: r32 = ua * ub;
        3'b100: r32 = (ub == 32'd0) ? '1 : ((ua == 32'h8000_0000 && ub == '1) ? ua : 32'(wa / wb));
        3'b101: r32 = (ub == 32'd0) ? '1 : ua / ub;
        3'b110: r32 = (ub == 32'd0) ? ua : ((ua == 32'h8000_0000 && ub == '1) ? 32'd0 : 32'(wa % wb));
        3'b111: r32 = (ub == 32'd0) ? ua : ua % ub;
        default: r32 = 32'd0;
      endcase
      r = {{32{r32[31]}}, r32};
    end
    return r;
  endfunction

  function automatic int exp_lat(input logic [2:0] f, input logic w,
                                 input logic [63:0] a, input logic [63:0] b);
    logic zero, ovf;
    zero = w ? (b[31:0] == 32'd0) : (b == 64'd0);
    ovf  = (f == 3'b100 || f == 3'b110) &&
           (w ? (a[31:0] == 32'h8000_0000 && b[31:0] == 32'hFFFF_FFFF)
              : (a == 64'h8000_0000_0000_0000 && b == '1));
    if (f[2] && (zero || ovf)) return 1;
    if (!f[2] && FAST) return 1;
    return w ? 33 : 65;
  endfunction

  // Issue one op, measure latency, check result/tag, hold in DONE, then hand off
  task automatic do_op(input logic [2:0] f, input logic w, input logic [63:0] a,
                       input logic [63:0] b, input logic [63:0] exp, input int hold, input string nm);
    int lat;
    logic [4:0] tg;
    tg = 5'($urandom_range(31, 1));
    @(negedge clk);
    in_valid = 1'b1; in_funct3 = f; in_word = w; in_src1 = a; in_src2 = b; in_tag = tg;
    chk({nm, "/in_ready_pre"}, 64'(in_ready), 64'd1);
    @(posedge clk); #1;
    in_valid = 1'b0;
    lat = 1;
    while (!out_valid && lat < 200) begin
      @(posedge clk); #1;
      lat++;
    end
    chk({nm, "/latency"}, 64'(lat), 64'(exp_lat(f, w, a, b)));
    chk({nm, "/res"}, out_res, exp);
    chk({nm, "/tag"}, 64'(out_tag), 64'(tg));
    chk({nm, "/in_ready_done"}, 64'(in_ready), 64'd0);
    for (int k = 0; k < hold; k++) begin
      @(posedge clk); #1;
      chk({nm, "/hold_res"}, out_res, exp);
      chk({nm, "/hold_valid"}, 64'(out_valid), 64'd1);
      chk({nm, "/hold_in_ready"}, 64'(in_ready), 64'd0);
    end
    @(negedge clk);
    out_ready = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b0;
    chk({nm, "/handoff_valid"}, 64'(out_valid), 64'd0);
    chk({nm, "/handoff_in_ready"}, 64'(in_ready), 64'd1);
    if (in_ready !== 1'b1) begin
      @(negedge clk); flush = 1'b1;
      @(negedge clk); flush = 1'b0;
    end
  endtask

  initial begin
    logic [2:0] f;
    logic w;
    logic [63:0] a, b;
    int rises;

    // Reset state
    repeat (2) @(posedge clk);
    #1;
    chk("rst/in_ready", 64'(in_ready), 64'd0);
    chk("rst/out_valid", 64'(out_valid), 64'd0);
    chk("rst/out_res", out_res, 64'd0);
    chk("rst/out_tag", 64'(out_tag), 64'd0);
    @(negedge clk); nrst = 1'b1;
    #1;
    chk("rst/in_ready_after", 64'(in_ready), 64'd1);

    // Directed corner cases
    do_op(3'b000, 1'b0, 64'd7, 64'hFFFF_FFFF_FFFF_FFFD, 64'hFFFF_FFFF_FFFF_FFEB, 0, "mul");
    do_op(3'b011, 1'b0, '1, '1, 64'hFFFF_FFFF_FFFF_FFFE, 0, "mulhu");
    do_op(3'b010, 1'b0, '1, 64'd2, 64'hFFFF_FFFF_FFFF_FFFF, 0, "mulhsu");
    do_op(3'b101, 1'b0, 64'd100, 64'd0, 64'hFFFF_FFFF_FFFF_FFFF, 0, "divu0");
    do_op(3'b111, 1'b0, 64'd100, 64'd0, 64'd100, 0, "remu0");
    do_op(3'b100, 1'b0, 64'h8000_0000_0000_0000, '1, 64'h8000_0000_0000_0000, 0, "div_ovf");
    do_op(3'b110, 1'b0, 64'h8000_0000_0000_0000, '1, 64'd0, 0, "rem_ovf");
    do_op(3'b100, 1'b1, 64'h0000_0001_8000_0000, 64'hFFFF_FFFF, 64'hFFFF_FFFF_8000_0000, 0, "divw_ovf");
    do_op(3'b000, 1'b1, 64'h7FFF_FFFF, 64'd2, 64'hFFFF_FFFF_FFFF_FFFE, 0, "mulw");
    do_op(3'b100, 1'b1, 64'd7, 64'hFFFF_FFFE, 64'hFFFF_FFFF_FFFF_FFFD, 0, "divw");
    do_op(3'b110, 1'b1, 64'd7, 64'hFFFF_FFFE, 64'd1, 0, "remw");
    do_op(3'b101, 1'b1, 64'hFFFF_FFFF, 64'd1, 64'hFFFF_FFFF_FFFF_FFFF, 0, "divuw");
    do_op(3'b001, 1'b1, 64'd5, 64'd6, 64'd0, 0, "mulh_word");
    do_op(3'b100, 1'b0, 64'hFFFF_FFFF_FFFF_FF9C, 64'd7, 64'hFFFF_FFFF_FFFF_FFF2, 5, "div_hold5");

    // Flush wins over a simultaneous accept
    @(negedge clk);
    in_valid = 1'b1; flush = 1'b1; in_funct3 = 3'b101; in_word = 1'b0;
    in_src1 = 64'd100; in_src2 = 64'd0;
    @(posedge clk); #1;
    in_valid = 1'b0; flush = 1'b0;
    chk("flush_acc/out_valid", 64'(out_valid), 64'd0);
    chk("flush_acc/in_ready", 64'(in_ready), 64'd1);

    // Flush 10 cycles into BUSY
    @(negedge clk);
    in_valid = 1'b1; in_funct3 = 3'b101; in_src1 = 64'd1000; in_src2 = 64'd7;
    @(posedge clk); #1;
    in_valid = 1'b0;
    repeat (10) @(posedge clk);
    #1;
    chk("flush/in_ready_busy", 64'(in_ready), 64'd0);
    @(negedge clk); flush = 1'b1;
    @(posedge clk); #1;
    flush = 1'b0;
    chk("flush/in_ready", 64'(in_ready), 64'd1);
    rises = 0;
    for (int k = 0; k < 70; k++) begin
      if (out_valid) rises++;
      @(posedge clk); #1;
    end
    chk("flush/no_valid", 64'(rises), 64'd0);

    // Reset asserted mid-BUSY (previous result and tag are non-zero)
    do_op(3'b000, 1'b0, 64'd3, 64'd5, 64'd15, 0, "pre_rst");
    @(negedge clk);
    in_valid = 1'b1; in_funct3 = 3'b000; in_src1 = 64'd9; in_src2 = 64'd9; in_tag = 5'd17;
    @(posedge clk); #1;
    in_valid = 1'b0;
    repeat (10) @(posedge clk);
    @(negedge clk); nrst = 1'b0;
    @(posedge clk); #1;
    chk("rst_busy/out_valid", 64'(out_valid), 64'd0);
    chk("rst_busy/out_res", out_res, 64'd0);
    chk("rst_busy/out_tag", 64'(out_tag), 64'd0);
    chk("rst_busy/in_ready", 64'(in_ready), 64'd0);
    @(negedge clk); nrst = 1'b1;
    @(posedge clk); #1;
    chk("rst_busy/in_ready_after", 64'(in_ready), 64'd1);
    chk("rst_busy/out_valid_after", 64'(out_valid), 64'd0);

    // Randomised ops against the model
    for (int i = 0; i < 24; i++) begin
      f = 3'($urandom_range(7, 0));
      w = 1'($urandom_range(1, 0));
      a = {$urandom, $urandom};
      b = {$urandom, $urandom};
      case ($urandom_range(4, 0))
        0: b = 64'($urandom_range(3, 0));
        1: b = '1;
        2: a = 64'($urandom_range(1000, 0));
        default: ;
      endcase
      do_op(f, w, a, b, model(f, w, a, b), $urandom_range(2, 0), "rand");
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
